// File: rtl/alu_pkg.sv
// ALU control codes and multiply sequencer state encoding shared
// by the EX stage.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_MUL = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mul_state_e;

endpackage

// File: rtl/mul_shift_add_dp.sv
// Shift-add multiply datapath: acc/mcand/mplier/cnt and one step per cycle.
// Ports: clk, rst, load/step controls, op_a/op_b, acc, last, nxt_zero.
module mul_shift_add_dp #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic [WIDTH-1:0] acc,
  output logic             last,
  output logic             nxt_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]    cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= op_a;
      mplier <= op_b;
      cnt    <= CW'(WIDTH);
    end else if (step) begin
      if (mplier[0])
        acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt - 1'b1;
    end
  end

  // This step is the final one of the fixed-length run.
  assign last     = (cnt == CW'(1));
  // Multiplier is all zeros once shifted by this step.
  assign nxt_zero = ~|mplier[WIDTH-1:1];

endmodule

// File: rtl/ex_mul_sequencer.sv
// EX-stage multi-cycle multiply sequencer with pipeline stall and result mux.
// Ports: clk, rst, ex_valid, alu_ctrl, op_a, op_b, alu_result, flush ->
// ex_result, stall, mul_busy. Option macro: EX_MUL_EARLY_TERM_EN.
module ex_mul_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             flush,
  output logic [WIDTH-1:0] ex_result,
  output logic             stall,
  output logic             mul_busy
);

`ifdef EX_MUL_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  mul_state_e state;
  mul_state_e nstate;

  logic             start;
  logic             load;
  logic             step;
  logic             last;
  logic             nxt_zero;
  logic [WIDTH-1:0] acc;

  assign start = ex_valid & (alu_ctrl == ALU_MUL) & ~flush;
  assign load  = (state == ST_IDLE) & start;
  assign step  = (state == ST_BUSY) & ~flush;

  mul_shift_add_dp #(
    .WIDTH(WIDTH)
  ) u_dp (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .step     (step),
    .op_a     (op_a),
    .op_b     (op_b),
    .acc      (acc),
    .last     (last),
    .nxt_zero (nxt_zero)
  );

  always_comb begin
    nstate = state;
    unique case (1'b1)
      (state == ST_IDLE): begin
        if (start)
          nstate = (EARLY && op_b == '0) ? ST_DONE : ST_BUSY;
      end
      (state == ST_BUSY): begin
        if (flush)
          nstate = ST_IDLE;
        else if (last || (EARLY && nxt_zero))
          nstate = ST_DONE;
      end
      (state == ST_DONE): nstate = ST_IDLE;
      default:            nstate = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= nstate;
  end

  // A flush in BUSY releases the pipeline in the same cycle.
  assign stall = ~rst & (load | step);

  assign ex_result = rst ? '0 :
                     (state == ST_DONE) ? acc : alu_result;

  assign mul_busy = ~rst & (state == ST_BUSY);

endmodule

// File: tb/tb_ex_mul_sequencer.sv
// Directed self-checking bench for ex_mul_sequencer.
// Honours EX_MUL_EARLY_TERM_EN when selecting expected stall counts.
module tb_ex_mul_sequencer;
  import alu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         ex_valid;
  logic [3:0]   alu_ctrl;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic [W-1:0] alu_result;
  logic         flush;
  logic [W-1:0] ex_result;
  logic         stall;
  logic         mul_busy;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ex_mul_sequencer #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .ex_valid   (ex_valid),
    .alu_ctrl   (alu_ctrl),
    .op_a       (op_a),
    .op_b       (op_b),
    .alu_result (alu_result),
    .flush      (flush),
    .ex_result  (ex_result),
    .stall      (stall),
    .mul_busy   (mul_busy)
  );

  task automatic chk(input string tag, input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_alu(input logic [3:0] c, input logic [W-1:0] r);
    ex_valid   = 1'b1;
    alu_ctrl   = c;
    alu_result = r;
  endtask

  // Starts just after a posedge in IDLE; returns at the DONE-cycle negedge.
  task automatic run_mul(input string tag, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] exp,
                         input int early_stalls);
    int n;
    int exp_st;
    bit done;
`ifdef EX_MUL_EARLY_TERM_EN
    exp_st = early_stalls;
`else
    exp_st = W + 1;
`endif
    n = 0;
    done = 0;
    ex_valid = 1'b1;
    alu_ctrl = ALU_MUL;
    op_a = a;
    op_b = b;
    alu_result = 32'hDEAD_0000;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (stall) begin
        chk({tag, "_busy"}, {31'd0, mul_busy}, {31'd0, n > 0});
        n++;
        @(posedge clk);
        #1;
        drive_alu(ALU_ADD, 32'hDEAD_0001);
      end else begin
        done = 1;
      end
    end
    chk({tag, "_done_seen"}, {31'd0, done}, 32'd1);
    chk({tag, "_stalls"}, n, exp_st);
    chk({tag, "_result"}, ex_result, exp);
    chk({tag, "_done_busy"}, {31'd0, mul_busy}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    op_a = 32'h1111_1111;
    op_b = 32'h2222_2222;
    drive_alu(ALU_MUL, 32'h5555_AAAA);

    // Reset: all outputs forced low even with a MUL presented.
    @(negedge clk);
    chk("rst_result", ex_result, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_busy", {31'd0, mul_busy}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive_alu(ALU_ADD, 32'h0000_0007);

    // ADD pass-through.
    @(negedge clk);
    chk("add_result", ex_result, 32'h7);
    chk("add_stall", {31'd0, stall}, 32'd0);
    @(posedge clk);
    #1;
    drive_alu(ALU_OR, 32'hCAFE_F00D);
    @(negedge clk);
    chk("or_result", ex_result, 32'hCAFE_F00D);
    chk("or_stall", {31'd0, stall}, 32'd0);
    @(posedge clk);
    #1;

    run_mul("mul3x5", 32'h3, 32'h5, 32'hF, 4);
    @(posedge clk);
    #1;
    drive_alu(ALU_SUB, 32'h0000_0042);
    @(negedge clk);
    chk("post_mul_idle", ex_result, 32'h42);
    chk("post_mul_stall", {31'd0, stall}, 32'd0);
    @(posedge clk);
    #1;

    run_mul("wrap", 32'hFFFF_FFFF, 32'h2, 32'hFFFF_FFFE, 3);
    @(posedge clk);
    #1;

    // Flush at T+10 of a long multiply.
    drive_alu(ALU_MUL, 32'h0);
    op_a = 32'h1234_5678;
    op_b = 32'h8000_0000;
    @(negedge clk);
    chk("fl_t0_stall", {31'd0, stall}, 32'd1);
    for (int i = 1; i < 10; i++) begin
      @(posedge clk);
      #1;
      drive_alu(ALU_ADD, 32'h1);
      @(negedge clk);
      chk("fl_busy_stall", {31'd0, stall}, 32'd1);
    end
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    chk("fl_t10_stall", {31'd0, stall}, 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    drive_alu(ALU_ADD, 32'h0000_0009);
    @(negedge clk);
    chk("fl_t11_result", ex_result, 32'h9);
    chk("fl_t11_stall", {31'd0, stall}, 32'd0);
    chk("fl_t11_busy", {31'd0, mul_busy}, 32'd0);
    @(posedge clk);
    #1;

    // Reset at T+5 of a multiply.
    drive_alu(ALU_MUL, 32'h0);
    op_a = 32'h1234_5678;
    op_b = 32'h8000_0000;
    for (int i = 1; i < 5; i++) begin
      @(posedge clk);
      #1;
      drive_alu(ALU_ADD, 32'h3);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mrst_result", ex_result, 32'd0);
    chk("mrst_stall", {31'd0, stall}, 32'd0);
    chk("mrst_busy", {31'd0, mul_busy}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive_alu(ALU_AND, 32'h0000_00A5);
    @(negedge clk);
    chk("mrst_idle_result", ex_result, 32'hA5);
    chk("mrst_idle_stall", {31'd0, stall}, 32'd0);
    chk("mrst_idle_busy", {31'd0, mul_busy}, 32'd0);
    @(posedge clk);
    #1;
    run_mul("mul7x6", 32'h7, 32'h6, 32'd42, 4);
    @(posedge clk);
    #1;

    run_mul("mul_b0", 32'h1234, 32'h0, 32'h0, 1);
    @(posedge clk);
    #1;
    run_mul("mul_b1", 32'h1234, 32'h1, 32'h1234, 2);
    @(posedge clk);
    #1;

    // Back-to-back: second MUL presented in the IDLE cycle after DONE.
    run_mul("b2b_1", 32'h10, 32'h10, 32'h100, 6);
    @(posedge clk);
    #1;
    run_mul("b2b_2", 32'hFFFF, 32'hFFFF, 32'hFFFE_0001, 17);
    @(posedge clk);
    #1;
    drive_alu(ALU_ADD, 32'h0000_0077);
    @(negedge clk);
    chk("final_idle", ex_result, 32'h77);
    chk("final_stall", {31'd0, stall}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
